// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory-mapped I/O controller.
// Contains the statistics block word offsets, the ctrl register bit positions,
// the counter saturation value and the debug-master FSM state encoding.
package mmio_pkg;

    // Word offsets inside the 4-word statistics block
    localparam logic [1:0] OFS_BR    = 2'd0;
    localparam logic [1:0] OFS_HIT   = 2'd1;
    localparam logic [1:0] OFS_MISPR = 2'd2;
    localparam logic [1:0] OFS_CTRL  = 2'd3;

    // Bit positions inside the ctrl register
    localparam int CTRL_CLR_BIT = 0;
    localparam int CTRL_FRZ_BIT = 1;

    // Counters stick at this value instead of wrapping
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Debug master handshake states
    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_ARB  = 2'd1,
        DBG_DONE = 2'd2
    } dbg_state_t;

    // True when an address falls inside the word-aligned 4-word stats block
    function automatic logic is_stats_hit(input logic [15:0] addr,
                                          input logic [15:0] base);
        return (addr[15:2] == base[15:2]);
    endfunction

endpackage

// File: rtl/mmio_ctrl_br_stat_cnt.sv
// br_stat_cnt: one 16-bit branch statistics counter.
// Counts single-cycle inc pulses, saturates at all-ones, holds while frozen,
// and is zeroed by clr, which wins over a same-cycle increment.
module br_stat_cnt
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    input  logic        frz,
    output logic [15:0] count
);

    // Saturating count register; clear first, then a gated increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !frz && (count != CNT_MAX)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O controller on the CPU external bus.
// Decodes CPU (and, optionally, debug master) accesses either to the internal
// branch statistics block at STATS_BASE or out to the peripheral bus.
// The CPU always owns the bus when it is accessing; the debug master only gets
// cycles the CPU leaves idle.
// Build option: define MMIO_DBG_PORT_EN to include the debug master and its
// handshake FSM; without it the dbg_* outputs are tied to zero and the dbg_*
// inputs are ignored.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter logic [15:0] STATS_BASE = 16'hC000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_re,
    input  logic        cpu_we,
    output logic [15:0] cpu_rdata,

    input  logic        inc_br_cnt,
    input  logic        inc_hit_cnt,
    input  logic        inc_mispr_cnt,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_done,
    output logic [15:0] dbg_rdata,

    output logic [15:0] per_addr,
    output logic [15:0] per_wdata,
    output logic        per_re,
    output logic        per_we,
    input  logic [15:0] per_rdata
);

    logic        cpu_act;
    logic        own_re;
    logic        own_we;
    logic [15:0] own_addr;
    logic [15:0] own_wdata;
    logic        own_hit;
    logic        per_sel;
    logic [15:0] stats_rdata;
    logic [15:0] own_rdata;
    logic [15:0] ctrl_val;
    logic        ctrl_wr;
    logic        cnt_clr;
    logic        freeze;
    logic [15:0] br_cnt;
    logic [15:0] hit_cnt;
    logic [15:0] mispr_cnt;

    assign cpu_act = cpu_re | cpu_we;

`ifdef MMIO_DBG_PORT_EN

    dbg_state_t  state_q;
    dbg_state_t  state_d;
    logic        gnt_c;
    logic        done_c;
    logic [15:0] dbg_rdata_q;

    // Debug FSM state register and capture of granted read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DBG_IDLE;
            dbg_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_c && !dbg_we) begin
                dbg_rdata_q <= own_rdata;
            end
        end
    end

    // Debug FSM next state: wait for a CPU-idle cycle, then hold done until release
    always_comb begin
        state_d = state_q;
        gnt_c   = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            DBG_IDLE: begin
                if (dbg_req) begin
                    state_d = DBG_ARB;
                end
            end
            DBG_ARB: begin
                if (!dbg_req) begin
                    state_d = DBG_IDLE;
                end else if (!cpu_act) begin
                    gnt_c   = 1'b1;
                    state_d = DBG_DONE;
                end
            end
            DBG_DONE: begin
                done_c = 1'b1;
                if (!dbg_req) begin
                    state_d = DBG_IDLE;
                end
            end
            default: begin
                state_d = DBG_IDLE;
            end
        endcase
    end

    assign dbg_gnt   = gnt_c;
    assign dbg_done  = done_c;
    assign dbg_rdata = dbg_rdata_q;

`else

    logic unused_dbg;

    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};
    assign dbg_gnt    = 1'b0;
    assign dbg_done   = 1'b0;
    assign dbg_rdata  = '0;

`endif

    // Bus owner mux: CPU first, then a granted debug access, otherwise nobody
    always_comb begin
        own_re    = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        if (cpu_act) begin
            own_re    = cpu_re;
            own_we    = cpu_we;
            own_addr  = cpu_addr;
            own_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            own_re    = ~dbg_we;
            own_we    = dbg_we;
            own_addr  = dbg_addr;
            own_wdata = dbg_wdata;
        end
    end

    assign own_hit = is_stats_hit(own_addr, STATS_BASE);
    assign per_sel = (own_re | own_we) & ~own_hit;

    // Peripheral bus only sees owner accesses that miss the stats block
    always_comb begin
        per_re    = 1'b0;
        per_we    = 1'b0;
        per_addr  = '0;
        per_wdata = '0;
        if (per_sel) begin
            per_re    = own_re;
            per_we    = own_we;
            per_addr  = own_addr;
            per_wdata = own_wdata;
        end
    end

    // Stats block read mux; ctrl reads back only the freeze flag
    always_comb begin
        ctrl_val               = '0;
        ctrl_val[CTRL_FRZ_BIT] = freeze;
        stats_rdata            = '0;
        case (own_addr[1:0])
            OFS_BR:    stats_rdata = br_cnt;
            OFS_HIT:   stats_rdata = hit_cnt;
            OFS_MISPR: stats_rdata = mispr_cnt;
            OFS_CTRL:  stats_rdata = ctrl_val;
            default:   stats_rdata = '0;
        endcase
    end

    assign own_rdata = own_hit ? stats_rdata : per_rdata;
    assign cpu_rdata = cpu_re ? own_rdata : '0;

    assign ctrl_wr = own_we & own_hit & (own_addr[1:0] == OFS_CTRL);
    assign cnt_clr = ctrl_wr & own_wdata[CTRL_CLR_BIT];

    // Sticky freeze flag, rewritten by every ctrl write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= own_wdata[CTRL_FRZ_BIT];
        end
    end

    br_stat_cnt u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_br_cnt),
        .clr   (cnt_clr),
        .frz   (freeze),
        .count (br_cnt)
    );

    br_stat_cnt u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_hit_cnt),
        .clr   (cnt_clr),
        .frz   (freeze),
        .count (hit_cnt)
    );

    br_stat_cnt u_mispr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_mispr_cnt),
        .clr   (cnt_clr),
        .frz   (freeze),
        .count (mispr_cnt)
    );

endmodule
